// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Control sequencer that runs the 16-bit CPU datapath in multicycle mode.
// Every instruction steps through FETCH / DECODE / execute / memory /
// write-back states, and this block drives every datapath select and enable.
// Instructions and data share one memory, and any access to it may stall.
//
// Ports
//   clock_i           rising-edge system clock
//   reset_i           asynchronous, active-high reset
//   start_i           leaves IDLE for FETCH; ignored in every other state
//   opcode_i[3:0]     IR[15:12], valid from DECODE onward (IR is held)
//   alu_zero_i        ALU zero flag, used in BRANCH
//   mem_ready_i       memory finishes the current request this cycle
//   mem_req_o         memory access request
//   mem_we_o          1 = write, 0 = read (meaningful only with mem_req_o)
//   mem_addr_src_o    memory address: 0 = PC, 1 = ALUOut
//   ir_write_o        load IR from memory
//   pc_write_o        load PC
//   pc_src_o[1:0]     PC source: 00 = ALU result (PC+2), 01 = ALUOut (target)
//   alu_src_a_o       ALU A: 0 = PC, 1 = rs
//   alu_src_b_o[1:0]  ALU B: 00 = rt, 01 = 2, 10 = sext(imm), 11 = sext(imm)<<1
//   alu_op_o[2:0]     000 add, 001 sub, 010 and, 011 or, 100 nor, 101 xor, 110 slt
//   reg_write_o       register file write enable
//   reg_dst_o         destination register: 0 = rt, 1 = rd
//   mem_to_reg_o      write data: 0 = ALUOut, 1 = memory data
//   halted_o          high while in HALT
//   fault_code_o[1:0] 00 none, 01 illegal opcode/state, 10 memory timeout (sticky)
//   retired_count_o   retired instruction count, saturating
//   state_dbg_o[3:0]  current state encoding
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int COUNT_W   = 16,
    parameter int TIMEOUT   = 15,
    parameter int TIMEOUT_W = 4
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [3:0]         opcode_i,
    input  logic               alu_zero_i,
    input  logic               mem_ready_i,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic               mem_addr_src_o,
    output logic               ir_write_o,
    output logic               pc_write_o,
    output logic [1:0]         pc_src_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [2:0]         alu_op_o,
    output logic               reg_write_o,
    output logic               reg_dst_o,
    output logic               mem_to_reg_o,
    output logic               halted_o,
    output logic [1:0]         fault_code_o,
    output logic [COUNT_W-1:0] retired_count_o,
    output logic [3:0]         state_dbg_o
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_WB_R     = 4'd4,
        S_EXEC_I   = 4'd5,
        S_WB_I     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_WB_MEM   = 4'd10,
        S_BRANCH   = 4'd11,
        S_HALT     = 4'd12,
        S_FAULT    = 4'd13
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    localparam logic [TIMEOUT_W-1:0] WAIT_LIMIT = TIMEOUT_W'(TIMEOUT);

    state_t               state_q, state_d;
    logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]           fault_code_q, fault_code_d;
    logic [COUNT_W-1:0]   retired_q, retired_d;

    logic       retire;
    logic [1:0] fault_reason;
    logic       mem_timeout;

    // Request has used its last allowed wait cycle; no ready now means fault.
    assign mem_timeout = (wait_cnt_q == WAIT_LIMIT) && !mem_ready_i;

    // -------------------------------------------------------------------------
    // State register and bookkeeping
    // -------------------------------------------------------------------------
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= '0;
            fault_code_q <= FAULT_NONE;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            fault_code_q <= fault_code_d;
            retired_q    <= retired_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and control outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        retire         = 1'b0;
        fault_reason   = FAULT_NONE;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_src_o = 1'b0;
        ir_write_o     = 1'b0;
        pc_write_o     = 1'b0;
        pc_src_o       = 2'b00;
        alu_src_a_o    = 1'b0;
        alu_src_b_o    = 2'b00;
        alu_op_o       = ALU_ADD;
        reg_write_o    = 1'b0;
        reg_dst_o      = 1'b0;
        mem_to_reg_o   = 1'b0;
        halted_o       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                // Instruction read while the ALU forms PC+2 in parallel.
                mem_req_o   = 1'b1;
                alu_src_b_o = 2'b01;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = S_DECODE;
                end else if (mem_timeout) begin
                    state_d      = S_FAULT;
                    fault_reason = FAULT_TIMEOUT;
                end
            end

            S_DECODE: begin
                // ALU precomputes the branch target into ALUOut.
                alu_src_b_o = 2'b11;
                case (opcode_i)
                    4'h0, 4'h1, 4'h2, 4'h3,
                    4'h4, 4'h5, 4'h6:        state_d = S_EXEC_R;
                    4'h7:                    state_d = S_EXEC_I;
                    4'h8, 4'h9:              state_d = S_MEM_ADDR;
                    4'hA, 4'hB:              state_d = S_BRANCH;
                    4'hF:                    state_d = S_HALT;
                    default: begin
                        state_d      = S_FAULT;
                        fault_reason = FAULT_ILLEGAL;
                    end
                endcase
            end

            S_EXEC_R: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = opcode_i[2:0];
                state_d     = S_WB_R;
            end

            S_WB_R: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end

            S_EXEC_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                state_d     = S_WB_I;
            end

            S_WB_I: begin
                reg_write_o = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end

            S_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                state_d     = (opcode_i == 4'h9) ? S_MEM_WR : S_MEM_RD;
            end

            S_MEM_RD: begin
                mem_req_o      = 1'b1;
                mem_addr_src_o = 1'b1;
                if (mem_ready_i) begin
                    state_d = S_WB_MEM;
                end else if (mem_timeout) begin
                    state_d      = S_FAULT;
                    fault_reason = FAULT_TIMEOUT;
                end
            end

            S_MEM_WR: begin
                mem_req_o      = 1'b1;
                mem_we_o       = 1'b1;
                mem_addr_src_o = 1'b1;
                if (mem_ready_i) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (mem_timeout) begin
                    state_d      = S_FAULT;
                    fault_reason = FAULT_TIMEOUT;
                end
            end

            S_WB_MEM: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end

            S_BRANCH: begin
                // rs - rt decides; ALUOut already holds the target from DECODE.
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_SUB;
                pc_src_o    = 2'b01;
                pc_write_o  = (opcode_i == 4'hB) ? !alu_zero_i : alu_zero_i;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end

            S_HALT: begin
                halted_o = 1'b1;
            end

            S_FAULT: begin
                state_d = S_FAULT;
            end

            default: begin
                // Unused encodings are treated as an illegal-state fault.
                state_d      = S_FAULT;
                fault_reason = FAULT_ILLEGAL;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Wait counter, sticky fault code and retired counter
    // -------------------------------------------------------------------------
    always_comb begin
        wait_cnt_d   = wait_cnt_q;
        fault_code_d = fault_code_q;
        retired_d    = retired_q;

        // Clearing on every transition covers entry to FETCH/MEM_RD/MEM_WR;
        // the counter is only observed inside those states.
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (mem_req_o && !mem_ready_i) begin
            wait_cnt_d = wait_cnt_q + TIMEOUT_W'(1);
        end

        if ((state_d == S_FAULT) && (state_q != S_FAULT)) begin
            fault_code_d = fault_reason;
        end

        if (retire && (retired_q != {COUNT_W{1'b1}})) begin
            retired_d = retired_q + COUNT_W'(1);
        end
    end

    assign fault_code_o    = fault_code_q;
    assign retired_count_o = retired_q;
    assign state_dbg_o     = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [3:0]  opcode_i = 4'h0;
    logic        alu_zero_i = 1'b0;
    logic        mem_ready_i = 1'b0;
    logic        mem_req_o, mem_we_o, mem_addr_src_o, ir_write_o, pc_write_o;
    logic [1:0]  pc_src_o;
    logic        alu_src_a_o;
    logic [1:0]  alu_src_b_o;
    logic [2:0]  alu_op_o;
    logic        reg_write_o, reg_dst_o, mem_to_reg_o, halted_o;
    logic [1:0]  fault_code_o;
    logic [15:0] retired_count_o;
    logic [3:0]  state_dbg_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(
        .COUNT_W  (16),
        .TIMEOUT  (15),
        .TIMEOUT_W(4)
    ) dut (
        .clock_i        (clk),
        .reset_i        (rst),
        .start_i        (start_i),
        .opcode_i       (opcode_i),
        .alu_zero_i     (alu_zero_i),
        .mem_ready_i    (mem_ready_i),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_src_o (mem_addr_src_o),
        .ir_write_o     (ir_write_o),
        .pc_write_o     (pc_write_o),
        .pc_src_o       (pc_src_o),
        .alu_src_a_o    (alu_src_a_o),
        .alu_src_b_o    (alu_src_b_o),
        .alu_op_o       (alu_op_o),
        .reg_write_o    (reg_write_o),
        .reg_dst_o      (reg_dst_o),
        .mem_to_reg_o   (mem_to_reg_o),
        .halted_o       (halted_o),
        .fault_code_o   (fault_code_o),
        .retired_count_o(retired_count_o),
        .state_dbg_o    (state_dbg_o)
    );

    // Control word layout:
    // [15] mem_req [14] mem_we [13] mem_addr_src [12] ir_write [11] pc_write
    // [10:9] pc_src [8] alu_src_a [7:6] alu_src_b [5:3] alu_op
    // [2] reg_write [1] reg_dst [0] mem_to_reg
    logic [15:0] ctrl;
    assign ctrl = {mem_req_o, mem_we_o, mem_addr_src_o, ir_write_o, pc_write_o,
                   pc_src_o, alu_src_a_o, alu_src_b_o, alu_op_o,
                   reg_write_o, reg_dst_o, mem_to_reg_o};

    localparam logic [15:0] C_NONE     = 16'h0000;
    localparam logic [15:0] C_FETCH_W  = 16'h8040; // req, B=01
    localparam logic [15:0] C_FETCH_GO = 16'h9840; // req, ir_write, pc_write, B=01
    localparam logic [15:0] C_DECODE   = 16'h00C0; // B=11
    localparam logic [15:0] C_EXR_ADD  = 16'h0100; // A=rs, B=rt, add
    localparam logic [15:0] C_EXR_XOR  = 16'h0128; // A=rs, B=rt, xor
    localparam logic [15:0] C_WB_R     = 16'h0006; // reg_write, reg_dst
    localparam logic [15:0] C_EXI      = 16'h0180; // A=rs, B=imm, add
    localparam logic [15:0] C_WB_I     = 16'h0004; // reg_write
    localparam logic [15:0] C_MEM_RD   = 16'hA000; // req, addr=ALUOut
    localparam logic [15:0] C_WB_MEM   = 16'h0005; // reg_write, mem_to_reg
    localparam logic [15:0] C_MEM_WR   = 16'hE000; // req, we, addr=ALUOut
    localparam logic [15:0] C_BR_T     = 16'h0B08; // pc_write, pc_src=01, A=rs, sub
    localparam logic [15:0] C_BR_N     = 16'h0308; // pc_src=01, A=rs, sub

    typedef struct {
        logic        start;
        logic [3:0]  op;
        logic        az;
        logic        rdy;
        logic [3:0]  st;
        logic [15:0] ctl;
        logic [15:0] ret;
        logic        hlt;
        logic [1:0]  flt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic [3:0] op, input logic az, input logic rdy,
                       input logic [3:0] st, input logic [15:0] ctl, input logic [15:0] ret,
                       input logic hlt);
        vec_t v;
        v.start = s; v.op = op; v.az = az; v.rdy = rdy;
        v.st = st; v.ctl = ctl; v.ret = ret; v.hlt = hlt; v.flt = 2'b00;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // One cycle: apply inputs on the falling edge, let them settle, then sample.
    task automatic step(input logic s, input logic [3:0] op, input logic az, input logic rdy);
        @(negedge clk);
        start_i = s; opcode_i = op; alu_zero_i = az; mem_ready_i = rdy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        start_i = 1'b0; mem_ready_i = 1'b0; opcode_i = 4'h0; alu_zero_i = 1'b0;
        rst = 1'b1;
        #2;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one ADD from IDLE so that retired_count becomes 1 on reaching FETCH.
    task automatic run_add_from_idle();
        step(1'b1, 4'h0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 1'b0, 1'b1);
    endtask

    initial begin
        // Directed cycle-by-cycle program: ADD, XOR, ADDI, LW (fetch stall +
        // 3 read stalls), SW, BEQ/BNE taken and not taken, then HALT.
        add(0, 4'h0, 0, 0,  0, C_NONE,     0, 0);
        add(1, 4'h0, 0, 0,  0, C_NONE,     0, 0);
        add(0, 4'h0, 0, 1,  1, C_FETCH_GO, 0, 0);
        add(0, 4'h0, 0, 1,  2, C_DECODE,   0, 0);
        add(0, 4'h0, 0, 1,  3, C_EXR_ADD,  0, 0);
        add(0, 4'h0, 0, 1,  4, C_WB_R,     0, 0);
        add(0, 4'h5, 0, 1,  1, C_FETCH_GO, 1, 0);
        add(0, 4'h5, 0, 1,  2, C_DECODE,   1, 0);
        add(0, 4'h5, 0, 0,  3, C_EXR_XOR,  1, 0);
        add(0, 4'h5, 0, 0,  4, C_WB_R,     1, 0);
        add(0, 4'h7, 0, 1,  1, C_FETCH_GO, 2, 0);
        add(0, 4'h7, 0, 0,  2, C_DECODE,   2, 0);
        add(0, 4'h7, 0, 0,  5, C_EXI,      2, 0);
        add(0, 4'h7, 0, 0,  6, C_WB_I,     2, 0);
        add(0, 4'h8, 0, 0,  1, C_FETCH_W,  3, 0);
        add(0, 4'h8, 0, 1,  1, C_FETCH_GO, 3, 0);
        add(0, 4'h8, 0, 0,  2, C_DECODE,   3, 0);
        add(0, 4'h8, 0, 0,  7, C_EXI,      3, 0);
        add(0, 4'h8, 0, 0,  8, C_MEM_RD,   3, 0);
        add(0, 4'h8, 0, 0,  8, C_MEM_RD,   3, 0);
        add(0, 4'h8, 0, 0,  8, C_MEM_RD,   3, 0);
        add(0, 4'h8, 0, 1,  8, C_MEM_RD,   3, 0);
        add(0, 4'h8, 0, 0, 10, C_WB_MEM,   3, 0);
        add(0, 4'h9, 0, 1,  1, C_FETCH_GO, 4, 0);
        add(0, 4'h9, 0, 0,  2, C_DECODE,   4, 0);
        add(0, 4'h9, 0, 0,  7, C_EXI,      4, 0);
        add(0, 4'h9, 0, 1,  9, C_MEM_WR,   4, 0);
        add(0, 4'hA, 0, 1,  1, C_FETCH_GO, 5, 0);
        add(0, 4'hA, 1, 0,  2, C_DECODE,   5, 0);
        add(0, 4'hA, 1, 0, 11, C_BR_T,     5, 0);
        add(0, 4'hB, 1, 1,  1, C_FETCH_GO, 6, 0);
        add(0, 4'hB, 1, 0,  2, C_DECODE,   6, 0);
        add(0, 4'hB, 1, 0, 11, C_BR_N,     6, 0);
        add(0, 4'hB, 0, 1,  1, C_FETCH_GO, 7, 0);
        add(0, 4'hB, 0, 0,  2, C_DECODE,   7, 0);
        add(0, 4'hB, 0, 0, 11, C_BR_T,     7, 0);
        add(0, 4'hA, 0, 1,  1, C_FETCH_GO, 8, 0);
        add(0, 4'hA, 0, 0,  2, C_DECODE,   8, 0);
        add(0, 4'hA, 0, 0, 11, C_BR_N,     8, 0);
        add(0, 4'hF, 0, 1,  1, C_FETCH_GO, 9, 0);
        add(0, 4'hF, 0, 1,  2, C_DECODE,   9, 0);
        add(1, 4'hF, 0, 1, 12, C_NONE,     9, 1);

        // Reset state while reset is held.
        #3;
        chk("reset_state", 32'(state_dbg_o), 32'd0);
        chk("reset_ctrl", 32'(ctrl), 32'(C_NONE));
        chk("reset_retired", 32'(retired_count_o), 32'd0);
        chk("reset_fault", 32'(fault_code_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].start, vecs[i].op, vecs[i].az, vecs[i].rdy);
            chk($sformatf("row%0d_state", i), 32'(state_dbg_o), 32'(vecs[i].st));
            chk($sformatf("row%0d_ctrl", i), 32'(ctrl), 32'(vecs[i].ctl));
            chk($sformatf("row%0d_retired", i), 32'(retired_count_o), 32'(vecs[i].ret));
            chk($sformatf("row%0d_halted", i), 32'(halted_o), 32'(vecs[i].hlt));
            chk($sformatf("row%0d_fault", i), 32'(fault_code_o), 32'(vecs[i].flt));
        end
        $display("table: %0d rows applied", vecs.size());

        // HALT is terminal: start pulses and ready are ignored.
        for (int k = 0; k < 20; k++) begin
            step(k[0], 4'hF, 1'b0, 1'b1);
            chk($sformatf("halt%0d_state", k), 32'(state_dbg_o), 32'd12);
            chk($sformatf("halt%0d_halted", k), 32'(halted_o), 32'd1);
            chk($sformatf("halt%0d_ctrl", k), 32'(ctrl), 32'(C_NONE));
        end
        chk("halt_retired", 32'(retired_count_o), 32'd9);
        $display("halt: held 20 cycles");

        // Illegal opcode 0xD after one retired ADD.
        do_reset();
        run_add_from_idle();
        step(1'b0, 4'hD, 1'b0, 1'b1);
        chk("ill_fetch_retired", 32'(retired_count_o), 32'd1);
        step(1'b0, 4'hD, 1'b0, 1'b1);
        chk("ill_decode_state", 32'(state_dbg_o), 32'd2);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 4'hD, 1'b0, 1'b1);
            chk($sformatf("ill%0d_state", k), 32'(state_dbg_o), 32'd13);
            chk($sformatf("ill%0d_fault", k), 32'(fault_code_o), 32'd1);
            chk($sformatf("ill%0d_ctrl", k), 32'(ctrl), 32'(C_NONE));
            chk($sformatf("ill%0d_retired", k), 32'(retired_count_o), 32'd1);
        end
        $display("illegal opcode: fault_code=%0d", fault_code_o);

        // Fetch timeout: 16 cycles without ready.
        do_reset();
        step(1'b1, 4'h0, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 4'h0, 1'b0, 1'b0);
            chk($sformatf("to%0d_state", k), 32'(state_dbg_o), 32'd1);
            chk($sformatf("to%0d_ctrl", k), 32'(ctrl), 32'(C_FETCH_W));
        end
        step(1'b0, 4'h0, 1'b0, 1'b0);
        chk("to_fault_state", 32'(state_dbg_o), 32'd13);
        chk("to_fault_code", 32'(fault_code_o), 32'd2);
        chk("to_fault_ctrl", 32'(ctrl), 32'(C_NONE));
        $display("timeout: fault_code=%0d", fault_code_o);

        // Ready on the 16th cycle is still accepted.
        do_reset();
        step(1'b1, 4'h0, 1'b0, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            step(1'b0, 4'h0, 1'b0, 1'b0);
            chk($sformatf("late%0d_state", k), 32'(state_dbg_o), 32'd1);
        end
        step(1'b0, 4'h0, 1'b0, 1'b1);
        chk("late16_ctrl", 32'(ctrl), 32'(C_FETCH_GO));
        step(1'b0, 4'h0, 1'b0, 1'b0);
        chk("late_decode_state", 32'(state_dbg_o), 32'd2);
        chk("late_decode_fault", 32'(fault_code_o), 32'd0);
        $display("late ready: state=%0d", state_dbg_o);

        // Asynchronous reset in the middle of a stalled store.
        do_reset();
        run_add_from_idle();
        step(1'b0, 4'h9, 1'b0, 1'b1);
        step(1'b0, 4'h9, 1'b0, 1'b0);
        step(1'b0, 4'h9, 1'b0, 1'b0);
        step(1'b0, 4'h9, 1'b0, 1'b0);
        chk("arst_memwr_state", 32'(state_dbg_o), 32'd9);
        chk("arst_memwr_ctrl", 32'(ctrl), 32'(C_MEM_WR));
        chk("arst_pre_retired", 32'(retired_count_o), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_mem_req", 32'(mem_req_o), 32'd0);
        chk("arst_mem_we", 32'(mem_we_o), 32'd0);
        chk("arst_state", 32'(state_dbg_o), 32'd0);
        chk("arst_retired", 32'(retired_count_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        $display("async reset: state=%0d retired=%0d", state_dbg_o, retired_count_o);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
